// File: rtl/mrr_cfg_pkg.sv
// Shared types and defaults for the MRR gateway configuration sequencer.
//   cfg_state_t  : sequencer states (IDLE, DRAIN, FILL, COMMIT, ARM, RUN)
//   SRC_CONST / SRC_HOST : window fill source encoding carried on cfg_src
//   *_DEF        : default widths and constants for the top-level parameters
package mrr_cfg_pkg;

    typedef enum logic [2:0] {
        IDLE,
        DRAIN,
        FILL,
        COMMIT,
        ARM,
        RUN
    } cfg_state_t;

    localparam logic SRC_CONST = 1'b0;
    localparam logic SRC_HOST  = 1'b1;

    localparam int          WIN_ADDR_W_DEF   = 10;
    localparam int          WIN_DATA_W_DEF   = 16;
    localparam int          THR_W_DEF        = 32;
    localparam int          DRAIN_CYCLES_DEF = 16;
    localparam logic [15:0] FILL_CONST_DEF   = 16'h7FFF;

endpackage

// File: rtl/mrr_pps_edge.sv
// Registered rising-edge detector for the 1PPS strobe.
//   clk      : gateway clock
//   rst      : asynchronous, active-high reset
//   pps      : 1PPS strobe, already synchronous to clk
//   pps_rise : one-cycle pulse, registered, the cycle after pps is first seen high
module mrr_pps_edge (
    input  logic clk,
    input  logic rst,
    input  logic pps,
    output logic pps_rise
);

    logic pps_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pps_q    <= 1'b0;
            pps_rise <= 1'b0;
        end else begin
            pps_q    <= pps;
            pps_rise <= pps & ~pps_q;
        end
    end

endmodule

// File: rtl/mrr_gateway_cfg_seq.sv
// Configuration sequencer for the MRR gateway core.
// Takes a live gateway offline, waits for its pipeline to drain, reloads the
// detection window RAM (constant fill or host stream), commits the new
// detection threshold and re-enables the gateway.
//
// Ports:
//   clk, rst              : gateway clock, asynchronous active-high reset
//   cfg_start             : one-cycle request to reconfigure (IDLE/RUN only)
//   cfg_stop              : abort; returns to IDLE with the gateway disabled
//   cfg_src, cfg_threshold: fill source and threshold, sampled with cfg_start
//   host_data/valid/ready : host coefficient stream used in host-fill mode
//   pps                   : 1PPS strobe (used only with MRR_CFG_PPS_ALIGN_EN)
//   win_we/addr/wdata     : window RAM write port
//   threshold, gw_enable  : committed threshold and gateway enable
//   busy, done            : sequence in progress / one-cycle RUN entry pulse
//
// Build option: define MRR_CFG_PPS_ALIGN_EN to hold ARM until a pps rising
// edge so the gateway enables on a second boundary.
module mrr_gateway_cfg_seq
    import mrr_cfg_pkg::*;
#(
    parameter int                    WIN_ADDR_W   = WIN_ADDR_W_DEF,
    parameter int                    WIN_DATA_W   = WIN_DATA_W_DEF,
    parameter int                    THR_W        = THR_W_DEF,
    parameter int                    DRAIN_CYCLES = DRAIN_CYCLES_DEF,
    parameter logic [WIN_DATA_W-1:0] FILL_CONST   = WIN_DATA_W'(FILL_CONST_DEF)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cfg_start,
    input  logic                  cfg_stop,
    input  logic                  cfg_src,
    input  logic [THR_W-1:0]      cfg_threshold,
    input  logic [WIN_DATA_W-1:0] host_data,
    input  logic                  host_valid,
    output logic                  host_ready,
    input  logic                  pps,
    output logic                  win_we,
    output logic [WIN_ADDR_W-1:0] win_addr,
    output logic [WIN_DATA_W-1:0] win_wdata,
    output logic [THR_W-1:0]      threshold,
    output logic                  gw_enable,
    output logic                  busy,
    output logic                  done
);

    localparam int                    DRAIN_W   = $clog2(DRAIN_CYCLES + 1);
    localparam logic [WIN_ADDR_W-1:0] LAST_ADDR = '1;

    cfg_state_t            state, state_d;
    logic                  src_q;
    logic [THR_W-1:0]      thr_q;
    logic [DRAIN_W-1:0]    drain_cnt;
    logic [WIN_ADDR_W-1:0] wr_addr;
    logic                  start_ok;
    logic                  accept;
    logic                  arm_go;

`ifdef MRR_CFG_PPS_ALIGN_EN
    logic pps_rise;

    mrr_pps_edge u_pps_edge (
        .clk      (clk),
        .rst      (rst),
        .pps      (pps),
        .pps_rise (pps_rise)
    );

    assign arm_go = pps_rise;
`else
    logic unused_pps;

    assign unused_pps = pps;
    assign arm_go     = 1'b1;
`endif

    // A write is taken every FILL cycle in constant mode, or on a host
    // handshake in host mode. host_ready is a register that is only high in
    // FILL, so it already gates host beats to the right state.
    always_comb begin
        // NOTE: every always_comb output gets a default first so that no
        // path through the case leaves it unassigned and infers a latch.
        start_ok = cfg_start && ((state == IDLE) || (state == RUN));
        accept   = (state == FILL) &&
                   ((src_q == SRC_CONST) || (host_valid && host_ready));
        state_d  = state;
        unique case (state)
            IDLE, RUN: if (start_ok) state_d = DRAIN;
            DRAIN:     if (drain_cnt == DRAIN_W'(DRAIN_CYCLES - 1)) state_d = FILL;
            FILL:      if (accept && (wr_addr == LAST_ADDR)) state_d = COMMIT;
            COMMIT:    state_d = ARM;
            ARM:       if (arm_go) state_d = RUN;
            default:   state_d = IDLE;
        endcase
        // Abort wins over everything, including a same-cycle cfg_start.
        if (cfg_stop) state_d = IDLE;
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_d;
    end

    // Outputs are registered from the next state, so they line up with the
    // state they describe rather than trailing it by a cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            src_q      <= SRC_CONST;
            thr_q      <= '0;
            drain_cnt  <= '0;
            wr_addr    <= '0;
            win_we     <= 1'b0;
            win_addr   <= '0;
            win_wdata  <= '0;
            threshold  <= '0;
            host_ready <= 1'b0;
            gw_enable  <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            if (start_ok && !cfg_stop) begin
                src_q <= cfg_src;
                thr_q <= cfg_threshold;
            end

            drain_cnt <= ((state == DRAIN) && (state_d == DRAIN)) ?
                         drain_cnt + DRAIN_W'(1) : '0;

            // The last address leaves FILL instead of wrapping to 0.
            if (state == DRAIN)
                wr_addr <= '0;
            else if (accept && !cfg_stop && (wr_addr != LAST_ADDR))
                wr_addr <= wr_addr + WIN_ADDR_W'(1);

            win_we <= accept && !cfg_stop;
            if (accept && !cfg_stop) begin
                win_addr  <= wr_addr;
                win_wdata <= (src_q == SRC_HOST) ? host_data : FILL_CONST;
            end

            // An abort during COMMIT keeps the previously committed value.
            if ((state == COMMIT) && !cfg_stop)
                threshold <= thr_q;

            host_ready <= (state_d == FILL) && (src_q == SRC_HOST);
            gw_enable  <= (state_d == RUN);
            busy       <= (state_d != IDLE) && (state_d != RUN);
            done       <= (state_d == RUN) && (state != RUN);
        end
    end

endmodule

// File: tb/tb_mrr_gateway_cfg_seq.sv
// Self-checking bench for mrr_gateway_cfg_seq (WIN_ADDR_W=4, DRAIN_CYCLES=4).
// Stimulus pushes expected RAM writes and committed thresholds into queues;
// a monitor pops and compares whenever the DUT writes or pulses done.
module tb_mrr_gateway_cfg_seq;

    localparam int          AW       = 4;
    localparam int          DW       = 16;
    localparam int          TW       = 32;
    localparam int          DRAIN_N  = 4;
    localparam int          DEPTH    = 1 << AW;
    localparam logic [DW-1:0] FILL_VAL = 16'h7FFF;

    logic          clk = 1'b0;
    logic          rst;
    logic          cfg_start, cfg_stop, cfg_src;
    logic [TW-1:0] cfg_threshold;
    logic [DW-1:0] host_data;
    logic          host_valid, host_ready, pps;
    logic          win_we;
    logic [AW-1:0] win_addr;
    logic [DW-1:0] win_wdata;
    logic [TW-1:0] threshold;
    logic          gw_enable, busy, done;

    always #5 clk = ~clk;

    mrr_gateway_cfg_seq #(
        .WIN_ADDR_W   (AW),
        .WIN_DATA_W   (DW),
        .THR_W        (TW),
        .DRAIN_CYCLES (DRAIN_N),
        .FILL_CONST   (FILL_VAL)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .cfg_start     (cfg_start),
        .cfg_stop      (cfg_stop),
        .cfg_src       (cfg_src),
        .cfg_threshold (cfg_threshold),
        .host_data     (host_data),
        .host_valid    (host_valid),
        .host_ready    (host_ready),
        .pps           (pps),
        .win_we        (win_we),
        .win_addr      (win_addr),
        .win_wdata     (win_wdata),
        .threshold     (threshold),
        .gw_enable     (gw_enable),
        .busy          (busy),
        .done          (done)
    );

    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } wr_t;

    wr_t           exp_wr[$];
    logic [TW-1:0] exp_thr[$];
    logic [DW-1:0] ram_model[DEPTH];
    logic [DW-1:0] ram_seen[DEPTH];
    logic [TW-1:0] committed;
    int            errors = 0;
    int            checks = 0;
    int            cycle_no = 0;
    int            first_wr_cyc;
    int            last_wr_cyc;
    logic          done_prev = 1'b0;
    wr_t           mon_w;
    logic [TW-1:0] mon_thr;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cycle_no);
        end
    endtask

    always @(posedge clk) cycle_no++;

    // Monitor: compares every DUT write and done pulse against the queues.
    always @(negedge clk) begin
        if (rst) begin
            done_prev = 1'b0;
        end else begin
            if (win_we) begin
                if (first_wr_cyc < 0) first_wr_cyc = cycle_no;
                last_wr_cyc = cycle_no;
                ram_seen[win_addr] = win_wdata;
                if (exp_wr.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_write: addr %0d data %h, none expected", win_addr, win_wdata);
                end else begin
                    mon_w = exp_wr.pop_front();
                    check("wr_addr", 64'(win_addr), 64'(mon_w.addr));
                    check("wr_data", 64'(win_wdata), 64'(mon_w.data));
                end
            end
            if (done) begin
                if (exp_thr.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done: threshold %h", threshold);
                end else begin
                    mon_thr = exp_thr.pop_front();
                    check("done_threshold", 64'(threshold), 64'(mon_thr));
                    check("done_gw_enable", 64'(gw_enable), 64'd1);
                end
                if (done_prev) begin
                    checks++;
                    errors++;
                    $display("FAIL done_width: done high on consecutive cycles");
                end
            end
            done_prev = done;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue_start(input logic src, input logic [TW-1:0] thr, output int start_edge);
        cfg_start     = 1'b1;
        cfg_src       = src;
        cfg_threshold = thr;
        tick();
        start_edge    = cycle_no;
        cfg_start     = 1'b0;
        cfg_src       = 1'($urandom);
        cfg_threshold = $urandom;
        check("start_gw_enable_low", 64'(gw_enable), 64'd0);
        check("start_busy", 64'(busy), 64'd1);
    endtask

    // One complete reconfiguration, checked end to end.
    task automatic run_seq(input logic src, input logic [TW-1:0] thr, input bit poke_busy, input int stall_pct);
        int start_edge;
        int beat;
        int cyc;
        logic [DW-1:0] d;
        first_wr_cyc = -1;
        if (src == 1'b0) begin
            for (int i = 0; i < DEPTH; i++) begin
                exp_wr.push_back('{addr: AW'(i), data: FILL_VAL});
                ram_model[i] = FILL_VAL;
            end
        end
        exp_thr.push_back(thr);
        issue_start(src, thr, start_edge);
        if (poke_busy) begin
            tick();
            cfg_start     = 1'b1;
            cfg_src       = ~src;
            cfg_threshold = thr ^ 32'hFFFF_0000;
            tick();
            cfg_start     = 1'b0;
        end
        if (src == 1'b1) begin
            beat = 0;
            cyc  = 0;
            while (beat < DEPTH && cyc < 2000) begin
                if (host_ready) begin
                    host_valid = ($urandom_range(0, 99) >= stall_pct);
                    if (host_valid) begin
                        d = DW'(beat) ^ 16'hA5A5;
                        host_data = d;
                        exp_wr.push_back('{addr: AW'(beat), data: d});
                        ram_model[beat] = d;
                        beat++;
                    end else begin
                        host_data = DW'($urandom);
                    end
                end else begin
                    host_valid = 1'($urandom);
                    host_data  = DW'($urandom);
                end
                tick();
                cyc++;
            end
            host_valid = 1'b0;
            check("host_beats", 64'(beat), 64'(DEPTH));
            check("ready_drops_after_last", 64'(host_ready), 64'd0);
        end
`ifdef MRR_CFG_PPS_ALIGN_EN
        cyc = 0;
        while (exp_wr.size() != 0 && cyc < 500) begin
            tick();
            cyc++;
        end
        repeat (50) tick();
        check("no_enable_before_pps", 64'(gw_enable), 64'd0);
        pps = 1'b1;
        tick();
        pps = 1'b0;
        check("enable_waits_edge_reg", 64'(gw_enable), 64'd0);
        tick();
        check("enable_after_pps_edge", 64'(gw_enable), 64'd1);
`endif
        cyc = 0;
        while (!done && cyc < 500) begin
            tick();
            cyc++;
        end
        check("done_seen", 64'(done), 64'd1);
`ifndef MRR_CFG_PPS_ALIGN_EN
        if (src == 1'b0) begin
            check("const_latency", 64'(cycle_no - start_edge), 64'(DRAIN_N + DEPTH + 2));
            check("const_consecutive", 64'(last_wr_cyc - first_wr_cyc), 64'(DEPTH - 1));
        end
`endif
        tick();
        check("run_gw_enable", 64'(gw_enable), 64'd1);
        check("run_busy", 64'(busy), 64'd0);
        check("done_one_cycle", 64'(done), 64'd0);
        check("run_threshold", 64'(threshold), 64'(thr));
        check("writes_drained", 64'(exp_wr.size()), 64'd0);
        for (int i = 0; i < DEPTH; i++)
            check("ram_contents", 64'(ram_seen[i]), 64'(ram_model[i]));
        committed = thr;
    endtask

    initial begin
        int cyc;
        int se;
        rst           = 1'b1;
        cfg_start     = 1'b0;
        cfg_stop      = 1'b0;
        cfg_src       = 1'b0;
        cfg_threshold = '0;
        host_data     = '0;
        host_valid    = 1'b0;
        pps           = 1'b0;
        committed     = '0;
        first_wr_cyc  = -1;
        last_wr_cyc   = -1;
        for (int i = 0; i < DEPTH; i++) begin
            ram_model[i] = '0;
            ram_seen[i]  = '0;
        end

        repeat (3) tick();
        check("reset_gw_enable", 64'(gw_enable), 64'd0);
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_threshold", 64'(threshold), 64'd0);
        check("reset_win_we", 64'(win_we), 64'd0);
        check("reset_host_ready", 64'(host_ready), 64'd0);
        rst = 1'b0;
        tick();
        check("idle_busy", 64'(busy), 64'd0);

        // Constant fill, threshold 25.
        run_seq(1'b0, 32'd25, 1'b0, 0);

        // Host fill with stalls.
        run_seq(1'b1, $urandom, 1'b0, 50);

        // Stop and start together from RUN: stop wins.
        cfg_start     = 1'b1;
        cfg_stop      = 1'b1;
        cfg_threshold = $urandom;
        tick();
        cfg_start = 1'b0;
        cfg_stop  = 1'b0;
        check("stopstart_busy", 64'(busy), 64'd0);
        check("stopstart_gw_enable", 64'(gw_enable), 64'd0);
        repeat (3) tick();
        check("stopstart_still_idle", 64'(busy), 64'd0);
        check("stopstart_threshold", 64'(threshold), 64'(committed));

        // Start while busy is ignored.
        run_seq(1'b0, $urandom, 1'b1, 0);

        // Stop mid-FILL right after the write at address 7.
        for (int i = 0; i < 8; i++) begin
            exp_wr.push_back('{addr: AW'(i), data: FILL_VAL});
            ram_model[i] = FILL_VAL;
        end
        issue_start(1'b0, $urandom, se);
        cyc = 0;
        while (!(win_we && win_addr == AW'(7)) && cyc < 200) begin
            tick();
            cyc++;
        end
        check("stop_reached_addr7", 64'(win_addr), 64'd7);
        cfg_stop = 1'b1;
        tick();
        cfg_stop = 1'b0;
        check("stop_busy", 64'(busy), 64'd0);
        check("stop_win_we", 64'(win_we), 64'd0);
        check("stop_gw_enable", 64'(gw_enable), 64'd0);
        check("stop_host_ready", 64'(host_ready), 64'd0);
        check("stop_threshold", 64'(threshold), 64'(committed));
        repeat (30) tick();
        check("stop_stays_idle", 64'(busy | gw_enable), 64'd0);
        check("stop_writes_done", 64'(exp_wr.size()), 64'd0);

        // Asynchronous reset mid-FILL.
        for (int i = 0; i < DEPTH; i++) exp_wr.push_back('{addr: AW'(i), data: FILL_VAL});
        exp_thr.push_back(32'hABCD);
        issue_start(1'b0, 32'hABCD, se);
        cyc = 0;
        while (!(win_we && win_addr == AW'(5)) && cyc < 200) begin
            tick();
            cyc++;
        end
        #2 rst = 1'b1;
        #1;
        check("async_rst_outputs", 64'({win_we, gw_enable, busy, done, host_ready}), 64'd0);
        check("async_rst_addr_data", 64'({win_addr, win_wdata}), 64'd0);
        check("async_rst_threshold", 64'(threshold), 64'd0);
        exp_wr.delete();
        exp_thr.delete();
        committed = '0;
        for (int i = 0; i < 6; i++) ram_model[i] = FILL_VAL;
        tick();
        rst = 1'b0;
        tick();

        run_seq(1'b1, $urandom, 1'b0, 30);
        run_seq(1'b1, $urandom, 1'b0, 70);
        run_seq(1'b0, $urandom, 1'b0, 0);

        repeat (5) tick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
